// File: rtl/ls_pkg.sv
// Shared state/mode encodings for the life-support array and its compartment channels.
package ls_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_NORM = 2'd1,
    ST_DEF  = 2'd2,
    ST_STL  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    MD_NORM = 2'd0,
    MD_DEF  = 2'd1,
    MD_STL  = 2'd2,
    MD_RSV  = 2'd3
  } mode_t;

  // Reserved mode code falls back to normal operation.
  function automatic state_t mode_to_state(input logic [1:0] m);
    case (mode_t'(m))
      MD_DEF:  return ST_DEF;
      MD_STL:  return ST_STL;
      default: return ST_NORM;
    endcase
  endfunction

endpackage

// File: rtl/ls_channel.sv
// One compartment: saturating O2 and temperature tracking plus its fatal flag.
module ls_channel
  import ls_pkg::*;
#(
  parameter int W          = 8,
  parameter int TEMP_LIMIT = 100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         run,
  input  logic         stealth,
  input  logic [W-1:0] o2_init,
  input  logic [W-1:0] temp_set,
  input  logic         o2sup,
  output logic [W-1:0] o2,
  output logic [W-1:0] temp,
  output logic         fatal
);

  localparam logic [W-1:0] LIMIT = W'(TEMP_LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o2   <= '0;
      temp <= '0;
    end else if (load) begin
      o2   <= o2_init;
      temp <= temp_set;
    end else if (run) begin
      if (o2sup) o2 <= (o2 == '1) ? o2 : o2 + W'(1);
      else       o2 <= (o2 == '0) ? o2 : o2 - W'(1);
      if (stealth)               temp <= (temp == '1) ? temp : temp + W'(1);
      else if (temp < temp_set)  temp <= temp + W'(1);
      else if (temp > temp_set)  temp <= temp - W'(1);
    end
  end

  assign fatal = run & ((temp >= LIMIT) | (o2 == '0));

endmodule

// File: rtl/life_support_array.sv
// Life-support controller: power/shield FSM plus CH compartment channels.
// Optional LS_STICKY_ALARM_EN latches alarm until load or reset.
module life_support_array
  import ls_pkg::*;
#(
  parameter int W          = 8,
  parameter int CH         = 4,
  parameter int TEMP_LIMIT = 100,
  parameter int SHIELD_MAX = 200,
  parameter int ATK_DMG    = 5,
  parameter int CHRG_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [W-1:0]    pwr_in,
  input  logic [W-1:0]    shield_in,
  input  logic [CH*W-1:0] o2_in,
  input  logic [CH*W-1:0] temp_set,
  input  logic [CH-1:0]   o2sup,
  input  logic            chrg,
  input  logic            atk,
  input  logic [1:0]      mode,
  output logic [W-1:0]    power,
  output logic [W-1:0]    shield,
  output logic [CH*W-1:0] o2,
  output logic [CH*W-1:0] temp,
  output logic [CH-1:0]   fatal,
  output logic            alarm,
  output logic [1:0]      state
);

  localparam logic [W:0]   CHRG = (W+1)'(CHRG_STEP);
  localparam logic [W-1:0] ATK  = W'(ATK_DMG);
  localparam logic [W-1:0] SMAX = W'(SHIELD_MAX);

  state_t       st;
  logic [W:0]   sum;
  logic [W-1:0] drain;
  logic [W-1:0] power_next;
  logic [W-1:0] shield_next;

  always_comb begin
    sum         = {1'b0, power} + CHRG;
    drain       = (st == ST_NORM) ? W'(1) : W'(2);
    power_next  = power;
    shield_next = shield;
    if (chrg) power_next = sum[W] ? '1 : sum[W-1:0];
    else      power_next = (power > drain) ? power - drain : '0;
    if (atk)                                shield_next = (shield > ATK) ? shield - ATK : '0;
    else if (st == ST_DEF && shield < SMAX) shield_next = shield + W'(1);
  end

  // Mode is honoured only while power remains; the transition uses pre-update power.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st     <= ST_OFF;
      power  <= '0;
      shield <= '0;
    end else if (load) begin
      st     <= ST_NORM;
      power  <= pwr_in;
      shield <= shield_in;
    end else if (st != ST_OFF) begin
      st     <= (power == '0) ? ST_NORM : mode_to_state(mode);
      power  <= power_next;
      shield <= shield_next;
    end
  end

  assign state = st;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    ls_channel #(.W(W), .TEMP_LIMIT(TEMP_LIMIT)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .run      (st != ST_OFF),
      .stealth  (st == ST_STL),
      .o2_init  (o2_in[i*W +: W]),
      .temp_set (temp_set[i*W +: W]),
      .o2sup    (o2sup[i]),
      .o2       (o2[i*W +: W]),
      .temp     (temp[i*W +: W]),
      .fatal    (fatal[i])
    );
  end

`ifdef LS_STICKY_ALARM_EN
  logic latched;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         latched <= 1'b0;
    else if (load)    latched <= 1'b0;
    else if (|fatal)  latched <= 1'b1;
  end
  assign alarm = latched | (|fatal);
`else
  assign alarm = |fatal;
`endif

endmodule

// File: tb/tb_life_support_array.sv
// Scoreboard bench for life_support_array: directed vectors, queued expectations, async monitor.
module tb_life_support_array;

  localparam int W = 8;
  localparam int CH = 4;
  localparam longint X = -1;
`ifdef LS_STICKY_ALARM_EN
  localparam longint STICKY = 1;
`else
  localparam longint STICKY = 0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            load = 1'b0;
  logic [W-1:0]    pwr_in = '0;
  logic [W-1:0]    shield_in = '0;
  logic [CH*W-1:0] o2_in = '0;
  logic [CH*W-1:0] temp_set = '0;
  logic [CH-1:0]   o2sup = '0;
  logic            chrg = 1'b0;
  logic            atk = 1'b0;
  logic [1:0]      mode = 2'd0;
  logic [W-1:0]    power;
  logic [W-1:0]    shield;
  logic [CH*W-1:0] o2;
  logic [CH*W-1:0] temp;
  logic [CH-1:0]   fatal;
  logic            alarm;
  logic [1:0]      state;

  life_support_array #(
    .W(W), .CH(CH), .TEMP_LIMIT(100), .SHIELD_MAX(200), .ATK_DMG(5), .CHRG_STEP(4)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .pwr_in(pwr_in), .shield_in(shield_in),
    .o2_in(o2_in), .temp_set(temp_set), .o2sup(o2sup), .chrg(chrg), .atk(atk),
    .mode(mode), .power(power), .shield(shield), .o2(o2), .temp(temp),
    .fatal(fatal), .alarm(alarm), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string  name;
    longint st, pw, sh, o2v, tp, fa, al;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  function automatic exp_t mk(string n, longint st, longint pw, longint sh,
                              longint o2v, longint tp, longint fa, longint al);
    exp_t e;
    e.name = n; e.st = st; e.pw = pw; e.sh = sh; e.o2v = o2v; e.tp = tp; e.fa = fa; e.al = al;
    return e;
  endfunction

  function automatic longint rep(input int v);
    logic [W-1:0] b;
    b = W'(v);
    return longint'({CH{b}});
  endfunction

  task automatic cmp(string n, string f, longint act, longint want);
    if (want < 0) return;
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s.%s got=%0h want=%0h", n, f, act, want);
    end
  endtask

  // Expectation for the value visible after the next rising edge.
  task automatic step(exp_t e);
    q.push_back(e);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk or negedge rst);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        cmp(e.name, "state",  longint'(state),  e.st);
        cmp(e.name, "power",  longint'(power),  e.pw);
        cmp(e.name, "shield", longint'(shield), e.sh);
        cmp(e.name, "o2",     longint'(o2),     e.o2v);
        cmp(e.name, "temp",   longint'(temp),   e.tp);
        cmp(e.name, "fatal",  longint'(fatal),  e.fa);
        cmp(e.name, "alarm",  longint'(alarm),  e.al);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    // Reset dominates a concurrent load request.
    load = 1'b1; pwr_in = 8'd50; shield_in = 8'd50; o2_in = 32'h05050505; temp_set = 32'h22222222;
    @(negedge clk);
    step(mk("rst_hold", 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b1; load = 1'b0; o2sup = 4'hF; chrg = 1'b1; atk = 1'b1;
    step(mk("off_hold", 0, 0, 0, 0, 0, 0, 0));

    // O2 depletion with supply off.
    chrg = 1'b0; atk = 1'b0; o2sup = 4'h0; mode = 2'd0;
    load = 1'b1; pwr_in = 8'd10; shield_in = 8'd100; o2_in = 32'h08080808; temp_set = 32'h22222222;
    step(mk("o2_load", 1, 10, 100, rep(8), rep(34), 0, 0));
    load = 1'b0;
    step(mk("o2_k1", 1, 9, 100, rep(7), rep(34), 0, 0));
    repeat (5) @(negedge clk);
    step(mk("o2_k7", 1, 3, 100, rep(1), rep(34), 0, 0));
    step(mk("o2_k8", 1, 2, 100, 0, rep(34), 15, 1));
    o2sup = 4'hF;
    step(mk("o2_recover", 1, 1, 100, rep(1), rep(34), 0, STICKY));

    // Defence drain: power exhaustion forces NORM despite mode DEF.
    load = 1'b1; pwr_in = 8'd6; shield_in = 8'd50; o2_in = 32'h32323232; mode = 2'd1;
    step(mk("def_load", 1, 6, 50, rep(50), rep(34), 0, 0));
    load = 1'b0;
    step(mk("def_c1", 2, 5, 50, rep(51), X, 0, 0));
    step(mk("def_c2", 2, 3, 51, X, X, X, X));
    step(mk("def_c3", 2, 1, 52, X, X, X, X));
    step(mk("def_c4", 2, 0, 53, X, X, X, X));
    step(mk("def_c5", 1, 0, 54, X, X, X, X));
    step(mk("def_c6", 1, 0, 54, X, X, 0, X));

    // Shield ceiling and attack saturation.
    load = 1'b1; pwr_in = 8'd200; shield_in = 8'd197;
    step(mk("sh_load", 1, 200, 197, X, X, X, X));
    load = 1'b0;
    step(mk("sh_c1", 2, 199, 197, X, X, X, X));
    step(mk("sh_c2", 2, 197, 198, X, X, X, X));
    step(mk("sh_c3", 2, 195, 199, X, X, X, X));
    step(mk("sh_c4", 2, 193, 200, X, X, X, X));
    step(mk("sh_c5", 2, 191, 200, X, X, X, X));
    step(mk("sh_c6", 2, 189, 200, X, X, X, X));
    load = 1'b1; pwr_in = 8'd200; shield_in = 8'd3;
    step(mk("atk_load", 1, 200, 3, X, X, X, X));
    load = 1'b0; atk = 1'b1;
    step(mk("atk_c1", 2, 199, 0, X, X, X, X));
    step(mk("atk_c2", 2, 197, 0, X, X, X, X));
    atk = 1'b0;
    step(mk("atk_regen", 2, 195, 1, X, X, X, X));

    // Stealth heating to the fatal limit, then cooling in NORM.
    load = 1'b1; pwr_in = 8'd50; shield_in = 8'd0; temp_set = 32'h61616161; mode = 2'd2;
    step(mk("stl_load", 1, 50, 0, rep(50), rep(97), 0, 0));
    load = 1'b0;
    step(mk("stl_c1", 3, 49, 0, X, rep(97), 0, X));
    step(mk("stl_c2", 3, 47, 0, X, rep(98), 0, X));
    step(mk("stl_c3", 3, 45, 0, X, rep(99), 0, X));
    step(mk("stl_c4", 3, 43, 0, X, rep(100), 15, 1));
    mode = 2'd0; temp_set = 32'h22222222;
    step(mk("cool_c1", 1, 41, 0, X, rep(101), 15, 1));
    step(mk("cool_c2", 1, 40, 0, X, rep(100), 15, 1));
    step(mk("cool_c3", 1, 39, 0, rep(57), rep(99), 0, STICKY));

    // Charge saturation; load beats a simultaneous attack.
    load = 1'b1; pwr_in = 8'd253; shield_in = 8'd100; chrg = 1'b1;
    step(mk("chg_load", 1, 253, 100, X, X, X, X));
    load = 1'b0;
    step(mk("chg_c1", 1, 255, 100, X, X, X, X));
    step(mk("chg_c2", 1, 255, 100, X, X, X, X));
    load = 1'b1; chrg = 1'b0; atk = 1'b1; pwr_in = 8'd100; shield_in = 8'd77;
    o2_in = 32'h000105FF; o2sup = 4'b0001;
    step(mk("ld_atk", 1, 100, 77, 32'h000105FF, rep(34), 8, 1));
    load = 1'b0; atk = 1'b0; temp_set = 32'h241E2222;
    step(mk("mix_c1", 1, 99, 77, 32'h000004FF, 32'h23212222, 12, 1));
    mode = 2'd2;
    step(mk("mix_c2", 3, 98, 77, 32'h000003FF, 32'h24202222, 12, 1));
    mode = 2'd3;
    step(mk("rsv_c3", 1, 96, 77, 32'h000002FF, 32'h25212323, 12, 1));

    // Asynchronous reset mid-cycle, then OFF until a fresh load.
    #2;
    q.push_back(mk("async_rst", 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; mode = 2'd0; o2sup = 4'hF;
    step(mk("post_rst", 0, 0, 0, 0, 0, 0, 0));
    load = 1'b1; pwr_in = 8'd9; shield_in = 8'd20; o2_in = 32'h0A0A0A0A; temp_set = 32'h22222222;
    step(mk("reload", 1, 9, 20, rep(10), rep(34), 0, 0));
    load = 1'b0;
    step(mk("reload_c1", 1, 8, 20, rep(11), rep(34), 0, 0));

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
